// File: rtl/apb_completer_mem.sv
// APB4 completer backed by a word-addressed memory with byte strobes,
// programmable wait states, range/privilege errors and protocol-violation flagging.
module apb_completer_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned WAIT_W     = 4
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [2:0]              pprot,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [WAIT_W-1:0]       cfg_wait,
    input  logic                    cfg_priv_only,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr,
    output logic                    prot_err
);

    localparam int unsigned NB     = DATA_WIDTH / 8;
    localparam int unsigned LSB    = $clog2(NB);
    localparam int unsigned IDX_W  = ADDR_WIDTH - LSB;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t                  r_state;
    logic [WAIT_W-1:0]       r_cnt;
    logic [MEM_AW-1:0]       r_idx;
    logic                    r_err;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [NB-1:0]           r_strb;
    logic [DATA_WIDTH-1:0]   r_rdq;
    logic                    r_prot_err;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic [IDX_W-1:0]        w_idx;
    logic [MEM_AW-1:0]       w_midx;
    logic                    w_err;
    logic                    w_pready;
    logic                    w_commit;
    logic                    w_unused;

    assign w_idx    = paddr[ADDR_WIDTH-1:LSB];
    assign w_midx   = MEM_AW'(w_idx);
    assign w_err    = (64'(w_idx) >= 64'(DEPTH)) || (cfg_priv_only && !pprot[0]);
    assign w_pready = (r_state == S_ACCESS) && (r_cnt == '0) && psel && penable;
    assign w_commit = w_pready && r_write && !r_err;
    assign w_unused = ^{pprot[2:1], paddr};

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_err      <= 1'b0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_rdq      <= '0;
            r_prot_err <= 1'b0;
        end else begin
            r_prot_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (psel && !penable) begin
                        r_idx   <= w_midx;
                        r_err   <= w_err;
                        r_write <= pwrite;
                        r_wdata <= pwdata;
                        r_strb  <= pstrb;
                        r_cnt   <= cfg_wait;
                        if (!pwrite && !w_err) begin
                            r_rdq <= r_mem[w_midx];
                        end
                        r_state <= S_ACCESS;
                    end else if (psel && penable) begin
                        r_prot_err <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    // Abort takes priority over the wait countdown; no write is committed.
                    if (!psel) begin
                        r_prot_err <= 1'b1;
                        r_state    <= S_IDLE;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - WAIT_W'(1);
                    end else if (penable) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (r_strb[b]) begin
                    r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    assign pready   = w_pready;
    assign pslverr  = w_pready && r_err;
    assign prdata   = (w_pready && !r_write && !r_err) ? r_rdq : '0;
    assign prot_err = r_prot_err;

endmodule

// File: tb/tb_apb_completer_mem.sv
// Self-checking bench for apb_completer_mem: directed scenarios plus randomized
// transfers compared against an array-based memory model.
module tb_apb_completer_mem;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 256;
    localparam int WW    = 4;

    logic          pclk = 1'b0;
    logic          preset = 1'b1;
    logic [AW-1:0] paddr = '0;
    logic [2:0]    pprot = '0;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [DW-1:0] pwdata = '0;
    logic [3:0]    pstrb = '0;
    logic [WW-1:0] cfg_wait = '0;
    logic          cfg_priv_only = 1'b0;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;
    logic          prot_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_mem [DEPTH];

    apb_completer_mem #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH(DEPTH),
        .WAIT_W(WW)
    ) dut (
        .pclk(pclk),
        .preset(preset),
        .paddr(paddr),
        .pprot(pprot),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .pwdata(pwdata),
        .pstrb(pstrb),
        .cfg_wait(cfg_wait),
        .cfg_priv_only(cfg_priv_only),
        .pready(pready),
        .prdata(prdata),
        .pslverr(pslverr),
        .prot_err(prot_err)
    );

    always #5 pclk = ~pclk;

    // Reference: an access is an error if it falls past the last word or is unprivileged under priv_only.
    function automatic void model_xfer(input logic [15:0] addr, input logic wr, input logic [31:0] wd,
                                       input logic [3:0] st, input logic [2:0] prot, input logic priv,
                                       output logic [31:0] erd, output logic ese);
        int unsigned idx;
        idx = int'(addr) / 4;
        ese = (idx >= DEPTH) || (priv && !prot[0]);
        erd = '0;
        if (!ese) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (st[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
            end else begin
                erd = model_mem[idx];
            end
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pclk); #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the completion edge with the bus released.
    task automatic xfer(input logic [15:0] addr, input logic wr, input logic [31:0] wd, input logic [3:0] st,
                        input logic [2:0] prot, input logic [3:0] wt, input logic priv,
                        output logic [31:0] rd, output logic se, output int cyc, output int quiet_bad);
        bit done;
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd; pstrb = st;
        pprot = prot; cfg_wait = wt; cfg_priv_only = priv;
        @(posedge pclk); #1;
        penable = 1'b1;
        paddr = 16'($urandom); pwdata = $urandom; cfg_wait = 4'($urandom); cfg_priv_only = 1'($urandom);
        pwrite = 1'($urandom);
        cyc = 1; quiet_bad = 0; rd = '0; se = 1'b0; done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge pclk);
            cyc++;
            if (pready === 1'b1) begin
                rd = prdata; se = pslverr; done = 1;
                break;
            end
            if (prdata !== '0 || pslverr !== 1'b0 || prot_err !== 1'b0) quiet_bad++;
            @(posedge pclk); #1;
        end
        if (done) begin
            @(posedge pclk); #1;
        end else begin
            cyc = -1;
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset;
        preset = 1'b1;
        repeat (3) @(negedge pclk);
        checks++; if (pready !== 1'b0) begin errors++; $display("FAIL reset_pready got %b exp 0", pready); end
        checks++; if (prdata !== '0) begin errors++; $display("FAIL reset_prdata got %h exp 0", prdata); end
        checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr got %b exp 0", pslverr); end
        checks++; if (prot_err !== 1'b0) begin errors++; $display("FAIL reset_prot_err got %b exp 0", prot_err); end
        @(posedge pclk); #1;
        preset = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        idle(1);
    endtask

    task automatic test_basic;
        logic [31:0] rd; logic se; int cyc, qb;
        xfer(16'h0010, 1'b1, 32'hDEADBEEF, 4'hF, 3'b001, 4'd0, 1'b0, rd, se, cyc, qb);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL basic_wr_cycles got %0d exp 2", cyc); end
        checks++; if (se !== 1'b0) begin errors++; $display("FAIL basic_wr_slverr got %b exp 0", se); end
        xfer(16'h0010, 1'b0, 32'h0, 4'h0, 3'b001, 4'd0, 1'b0, rd, se, cyc, qb);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL basic_rd_cycles got %0d exp 2", cyc); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_data got %h exp DEADBEEF", rd); end
        checks++; if (se !== 1'b0) begin errors++; $display("FAIL basic_rd_slverr got %b exp 0", se); end
        model_mem[4] = 32'hDEADBEEF;
        idle(1);
    endtask

    task automatic test_wait_states;
        logic [31:0] rd; logic se; int cyc, qb;
        xfer(16'h0010, 1'b0, 32'h0, 4'h0, 3'b000, 4'd3, 1'b0, rd, se, cyc, qb);
        checks++; if (cyc !== 5) begin errors++; $display("FAIL wait3_cycles got %0d exp 5", cyc); end
        checks++; if (qb !== 0) begin errors++; $display("FAIL wait3_quiet got %0d exp 0", qb); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wait3_data got %h exp DEADBEEF", rd); end
        idle(1);
    endtask

    task automatic test_strobes;
        logic [31:0] rd; logic se; int cyc, qb;
        xfer(16'h0010, 1'b1, 32'h11223344, 4'h5, 3'b000, 4'd1, 1'b0, rd, se, cyc, qb);
        xfer(16'h0012, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0, 1'b0, rd, se, cyc, qb);
        checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL strobe_merge got %h exp DE22BE44", rd); end
        xfer(16'h0010, 1'b1, 32'hFFFFFFFF, 4'h0, 3'b000, 4'd0, 1'b0, rd, se, cyc, qb);
        checks++; if (se !== 1'b0) begin errors++; $display("FAIL strobe0_slverr got %b exp 0", se); end
        xfer(16'h0010, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0, 1'b0, rd, se, cyc, qb);
        checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL strobe0_data got %h exp DE22BE44", rd); end
        model_mem[4] = 32'hDE22BE44;
        idle(1);
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic se; int cyc, qb;
        xfer(16'h0400, 1'b0, 32'h0, 4'h0, 3'b001, 4'd0, 1'b0, rd, se, cyc, qb);
        checks++; if (se !== 1'b1) begin errors++; $display("FAIL oor_rd_slverr got %b exp 1", se); end
        checks++; if (rd !== '0) begin errors++; $display("FAIL oor_rd_data got %h exp 0", rd); end
        xfer(16'h0400, 1'b1, 32'hCAFEF00D, 4'hF, 3'b001, 4'd0, 1'b0, rd, se, cyc, qb);
        checks++; if (se !== 1'b1) begin errors++; $display("FAIL oor_wr_slverr got %b exp 1", se); end
        xfer(16'h0000, 1'b0, 32'h0, 4'h0, 3'b001, 4'd0, 1'b0, rd, se, cyc, qb);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_wr_alias0 got %h exp 0", rd); end
        xfer(16'h03FC, 1'b0, 32'h0, 4'h0, 3'b001, 4'd0, 1'b0, rd, se, cyc, qb);
        checks++; if (rd !== 32'h0 || se !== 1'b0) begin errors++; $display("FAIL last_word got %h/%b exp 0/0", rd, se); end
        xfer(16'h0010, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0, 1'b1, rd, se, cyc, qb);
        checks++; if (se !== 1'b1 || rd !== '0) begin errors++; $display("FAIL priv_deny got %h/%b exp 0/1", rd, se); end
        xfer(16'h0010, 1'b1, 32'h0, 4'hF, 3'b110, 4'd0, 1'b1, rd, se, cyc, qb);
        checks++; if (se !== 1'b1) begin errors++; $display("FAIL priv_wr_deny got %b exp 1", se); end
        xfer(16'h0010, 1'b0, 32'h0, 4'h0, 3'b001, 4'd0, 1'b1, rd, se, cyc, qb);
        checks++; if (se !== 1'b0 || rd !== 32'hDE22BE44) begin errors++; $display("FAIL priv_allow got %h/%b exp DE22BE44/0", rd, se); end
        idle(1);
    endtask

    task automatic test_prot_err;
        logic [31:0] rd; logic se; int cyc, qb;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 16'h0010;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        checks++; if (prot_err !== 1'b1 || pready !== 1'b0) begin errors++; $display("FAIL noset_pulse got %b/%b exp 1/0", prot_err, pready); end
        @(negedge pclk);
        checks++; if (prot_err !== 1'b0) begin errors++; $display("FAIL noset_clear got %b exp 0", prot_err); end
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0020; pwdata = 32'hA5A5A5A5;
        pstrb = 4'hF; cfg_wait = 4'd2; cfg_priv_only = 1'b0;
        @(posedge pclk); #1; penable = 1'b1;
        @(posedge pclk); #1; psel = 1'b0; penable = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        checks++; if (prot_err !== 1'b1 || pready !== 1'b0) begin errors++; $display("FAIL abort_pulse got %b/%b exp 1/0", prot_err, pready); end
        @(posedge pclk); #1;
        xfer(16'h0020, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0, 1'b0, rd, se, cyc, qb);
        checks++; if (rd !== model_mem[8]) begin errors++; $display("FAIL abort_nowrite got %h exp %h", rd, model_mem[8]); end
        idle(1);
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic se; int cyc, qb;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0030; pwdata = 32'h12345678;
        pstrb = 4'hF; cfg_wait = 4'd5;
        @(posedge pclk); #1; penable = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b1;
        #1;
        checks++; if (pready !== 1'b0 || prdata !== '0 || pslverr !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs got %b/%h/%b exp 0/0/0", pready, prdata, pslverr); end
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        preset = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        idle(1);
        xfer(16'h0030, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0, 1'b0, rd, se, cyc, qb);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rstmid_discard got %h exp 0", rd); end
        xfer(16'h0010, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0, 1'b0, rd, se, cyc, qb);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rstmid_clear got %h exp 0", rd); end
    endtask

    task automatic test_random;
        logic [31:0] rd, erd, wd; logic se, ese, wr, priv; int cyc, qb, idx;
        logic [15:0] addr; logic [3:0] st, wt; logic [2:0] prot;
        addr = 16'h0;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(3, 0) != 0) begin
                idx = $urandom_range(287, 0);
                addr = 16'((idx << 2) | $urandom_range(3, 0));
            end
            wr = 1'($urandom); wd = $urandom; st = 4'($urandom); prot = 3'($urandom);
            wt = 4'($urandom_range(3, 0)); priv = ($urandom_range(3, 0) == 0);
            model_xfer(addr, wr, wd, st, prot, priv, erd, ese);
            xfer(addr, wr, wd, st, prot, wt, priv, rd, se, cyc, qb);
            checks++; if (rd !== erd) begin errors++; $display("FAIL rand_rdata[%0d] got %h exp %h", n, rd, erd); end
            checks++; if (se !== ese) begin errors++; $display("FAIL rand_slverr[%0d] got %b exp %b", n, se, ese); end
            checks++; if (cyc !== 2 + int'(wt)) begin errors++; $display("FAIL rand_cycles[%0d] got %0d exp %0d", n, cyc, 2 + int'(wt)); end
            checks++; if (qb !== 0) begin errors++; $display("FAIL rand_quiet[%0d] got %0d exp 0", n, qb); end
            if ($urandom_range(1, 0) == 1) idle($urandom_range(2, 1));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_strobes();
        test_errors();
        test_prot_err();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
